// File: rtl/float_to_fixed_converter.sv
// Multi-cycle IEEE-754 float to signed Q(OUT_LEN-FRAC_LEN).FRAC_LEN fixed-point converter.
// Define FP2FIX_ROUND_EN for round-to-nearest (ties away); default build truncates toward zero.
module float_to_fixed_converter #(
   parameter int unsigned EXP_LEN      = 8,
   parameter int unsigned MANTISSA_LEN = 23,
   parameter int unsigned OUT_LEN      = 32,
   parameter int unsigned FRAC_LEN     = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [EXP_LEN+MANTISSA_LEN:0]   a,
   input  logic                            inp_data_ready,
   output logic [OUT_LEN-1:0]              fixed_out,
   output logic                            out_ready,
   output logic                            overflow,
   output logic                            invalid
);

   localparam int unsigned ShW    = EXP_LEN + 2;
   localparam int          Bias   = 2 ** (EXP_LEN - 1) - 1;
   localparam int          SatExp = Bias + int'(OUT_LEN) - 1 - int'(FRAC_LEN);
   localparam logic [ShW-1:0]     ShOff  = ShW'(Bias + int'(MANTISSA_LEN) - int'(FRAC_LEN));
   localparam logic [OUT_LEN-1:0] PosSat = {1'b0, {(OUT_LEN-1){1'b1}}};
   localparam logic [OUT_LEN-1:0] NegSat = {1'b1, {(OUT_LEN-1){1'b0}}};

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StUnpack   = 3'd1,
      StClassify = 3'd2,
      StShift    = 3'd3,
      StRound    = 3'd4,
      StSign     = 3'd5,
      StDone     = 3'd6
   } state_e;

   state_e                   state_q, state_d;
   logic                     sign_q, sign_d;
   logic [EXP_LEN-1:0]       exp_q, exp_d;
   logic [MANTISSA_LEN:0]    mant_q, mant_d;
   logic signed [ShW-1:0]    sh_q, sh_d;
   logic [OUT_LEN-1:0]       mag_q, mag_d;
   logic                     guard_q, guard_d;
   logic [OUT_LEN-1:0]       res_q, res_d;
   logic                     ovf_q, ovf_d;
   logic                     inv_q, inv_d;
   logic [OUT_LEN-1:0]       fixed_out_d;
   logic                     out_ready_d, overflow_d, invalid_d;

   logic [ShW-1:0]           pos_sh, neg_sh;
   logic [MANTISSA_LEN+1:0]  ext;
   logic                     frac_zero;

   assign pos_sh    = sh_q;
   assign neg_sh    = -sh_q;
   // Extra LSB below the mantissa catches the last bit shifted out as the guard.
   assign ext       = {mant_q, 1'b0} >> neg_sh;
   assign frac_zero = (mant_q[MANTISSA_LEN-1:0] == '0);

   always_comb begin
      state_d     = state_q;
      sign_d      = sign_q;
      exp_d       = exp_q;
      mant_d      = mant_q;
      sh_d        = sh_q;
      mag_d       = mag_q;
      guard_d     = guard_q;
      res_d       = res_q;
      ovf_d       = ovf_q;
      inv_d       = inv_q;
      fixed_out_d = fixed_out;
      out_ready_d = out_ready;
      overflow_d  = overflow;
      invalid_d   = invalid;

      unique case (state_q)
         StIdle: begin
            out_ready_d = 1'b1;
            if (inp_data_ready) begin
               sign_d      = a[EXP_LEN+MANTISSA_LEN];
               exp_d       = a[EXP_LEN+MANTISSA_LEN-1 -: EXP_LEN];
               mant_d      = {1'b1, a[MANTISSA_LEN-1:0]};
               ovf_d       = 1'b0;
               inv_d       = 1'b0;
               out_ready_d = 1'b0;
               state_d     = StUnpack;
            end
         end
         StUnpack: begin
            sh_d    = {2'b00, exp_q} - ShOff;
            state_d = StClassify;
         end
         StClassify: begin
            if (exp_q == '0) begin
               res_d   = '0;
               state_d = StDone;
            end else if (&exp_q) begin
               if (!frac_zero) begin
                  res_d = '0;
                  inv_d = 1'b1;
               end else begin
                  res_d = sign_q ? NegSat : PosSat;
                  ovf_d = 1'b1;
               end
               state_d = StDone;
            end else if (int'(exp_q) >= SatExp &&
                         !(sign_q && frac_zero && int'(exp_q) == SatExp)) begin
               res_d   = sign_q ? NegSat : PosSat;
               ovf_d   = 1'b1;
               state_d = StDone;
            end else begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (!sh_q[ShW-1]) begin
               mag_d   = OUT_LEN'(mant_q) << pos_sh;
               guard_d = 1'b0;
            end else if (neg_sh > ShW'(MANTISSA_LEN + 1)) begin
               mag_d   = '0;
               guard_d = 1'b0;
            end else begin
               mag_d   = OUT_LEN'(ext[MANTISSA_LEN+1:1]);
               guard_d = ext[0];
            end
            state_d = StRound;
         end
         StRound: begin
`ifdef FP2FIX_ROUND_EN
            mag_d = mag_q + OUT_LEN'(guard_q);
`else
            mag_d = mag_q;
`endif
            state_d = StSign;
         end
         StSign: begin
            if (!sign_q) begin
               if (mag_q > PosSat) begin
                  res_d = PosSat;
                  ovf_d = 1'b1;
               end else begin
                  res_d = mag_q;
               end
            end else begin
               if (mag_q > NegSat) begin
                  res_d = NegSat;
                  ovf_d = 1'b1;
               end else begin
                  res_d = -mag_q;
               end
            end
            state_d = StDone;
         end
         StDone: begin
            fixed_out_d = res_q;
            overflow_d  = ovf_q;
            invalid_d   = inv_q;
            out_ready_d = 1'b1;
            state_d     = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         sign_q    <= 1'b0;
         exp_q     <= '0;
         mant_q    <= '0;
         sh_q      <= '0;
         mag_q     <= '0;
         guard_q   <= 1'b0;
         res_q     <= '0;
         ovf_q     <= 1'b0;
         inv_q     <= 1'b0;
         fixed_out <= '0;
         out_ready <= 1'b0;
         overflow  <= 1'b0;
         invalid   <= 1'b0;
      end else begin
         state_q   <= state_d;
         sign_q    <= sign_d;
         exp_q     <= exp_d;
         mant_q    <= mant_d;
         sh_q      <= sh_d;
         mag_q     <= mag_d;
         guard_q   <= guard_d;
         res_q     <= res_d;
         ovf_q     <= ovf_d;
         inv_q     <= inv_d;
         fixed_out <= fixed_out_d;
         out_ready <= out_ready_d;
         overflow  <= overflow_d;
         invalid   <= invalid_d;
      end
   end

endmodule

// File: tb/tb_float_to_fixed_converter.sv
// Scoreboard bench for float_to_fixed_converter: directed float operands with hand-derived results.
`timescale 1ns/1ps
module tb_float_to_fixed_converter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] a = '0;
   logic        inp_data_ready = 1'b0;
   logic [31:0] fixed_out;
   logic        out_ready, overflow, invalid;

   always #5 clk = ~clk;

   float_to_fixed_converter dut (
      .clk            (clk),
      .rst            (rst),
      .a              (a),
      .inp_data_ready (inp_data_ready),
      .fixed_out      (fixed_out),
      .out_ready      (out_ready),
      .overflow       (overflow),
      .invalid        (invalid)
   );

   typedef struct {
      logic [31:0] fx;
      bit          ov;
      bit          iv;
      int          lat;
      longint      t;
      string       nm;
   } exp_t;

   exp_t  sb[$];
   int    n_cmp = 0;
   int    n_fail = 0;
   bit    skip_rise = 1'b1;
   logic  prev_rdy = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Request is sampled at the posedge following the drive; its time stamps the latency origin.
   task automatic issue(input logic [31:0] v, input logic [31:0] fx, input bit ov, input bit iv,
                        input int lat, input string nm);
      exp_t e;
      @(negedge clk);
      a = v;
      inp_data_ready = 1'b1;
      @(posedge clk);
      e.fx = fx; e.ov = ov; e.iv = iv; e.lat = lat; e.t = longint'($time); e.nm = nm;
      sb.push_back(e);
      @(negedge clk);
      inp_data_ready = 1'b0;
      a = ~v;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL timeout: %0d results pending, expected 0", sb.size());
         sb.delete();
      end
   endtask

   task automatic convert(input logic [31:0] v, input logic [31:0] fx, input bit ov, input bit iv,
                          input int lat, input string nm);
      issue(v, fx, ov, iv, lat, nm);
      drain();
   endtask

   initial begin
      fork
         forever begin : monitor
            exp_t   e;
            longint dt;
            @(negedge clk);
            if (out_ready === 1'b1 && prev_rdy !== 1'b1) begin
               if (sb.size() == 0) begin
                  if (skip_rise) skip_rise = 1'b0;
                  else begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL unexpected_result: got fixed_out=%h, expected no result",
                              fixed_out);
                  end
               end else begin
                  e  = sb.pop_front();
                  dt = (longint'($time) - 5 - e.t) / 10;
                  check({e.nm, " value"}, fixed_out, e.fx);
                  check({e.nm, " overflow"}, 32'(overflow), 32'(e.ov));
                  check({e.nm, " invalid"}, 32'(invalid), 32'(e.iv));
                  check({e.nm, " latency"}, 32'(dt), 32'(e.lat));
               end
            end
            prev_rdy = out_ready;
         end
      join_none

      // Reset state
      repeat (2) @(negedge clk);
      check("reset fixed_out", fixed_out, 32'h0);
      check("reset out_ready", 32'(out_ready), 32'h0);
      check("reset overflow", 32'(overflow), 32'h0);
      check("reset invalid", 32'(invalid), 32'h0);
      skip_rise = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1 check("ready after reset", 32'(out_ready), 32'h1);

      convert(32'h3F800000, 32'h00000100, 0, 0, 6, "one");
      convert(32'hC0200000, 32'hFFFFFD80, 0, 0, 6, "neg2p5");
      convert(32'h3B800000, 32'h00000001, 0, 0, 6, "2^-8");
`ifdef FP2FIX_ROUND_EN
      convert(32'h3B000000, 32'h00000001, 0, 0, 6, "2^-9");
      convert(32'hBB000000, 32'hFFFFFFFF, 0, 0, 6, "-2^-9");
      convert(32'h3BC00000, 32'h00000002, 0, 0, 6, "1.5*2^-8");
`else
      convert(32'h3B000000, 32'h00000000, 0, 0, 6, "2^-9");
      convert(32'hBB000000, 32'h00000000, 0, 0, 6, "-2^-9");
      convert(32'h3BC00000, 32'h00000001, 0, 0, 6, "1.5*2^-8");
`endif
      convert(32'h501502F9, 32'h7FFFFFFF, 1, 0, 3, "1e10");
      convert(32'hCB000000, 32'h80000000, 0, 0, 6, "-2^23");
      convert(32'hCB000001, 32'h80000000, 1, 0, 3, "below -2^23");
      convert(32'h4B000000, 32'h7FFFFFFF, 1, 0, 3, "+2^23");
      convert(32'h4AFFFFFF, 32'h7FFFFF80, 0, 0, 6, "max below 2^23");
      convert(32'h7FC00000, 32'h00000000, 0, 1, 3, "nan");
      convert(32'h00000001, 32'h00000000, 0, 0, 3, "denormal");
      convert(32'hFF800000, 32'h80000000, 1, 0, 3, "-inf");

      // Request pulsed mid-conversion must be ignored
      issue(32'h3F800000, 32'h00000100, 0, 0, 6, "pulse");
      @(posedge clk);
      @(negedge clk);
      a = 32'h7FC00000;
      inp_data_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inp_data_ready = 1'b0;
      drain();
      repeat (8) @(negedge clk);

      convert(32'h7F800000, 32'h7FFFFFFF, 1, 0, 3, "+inf");

      // Abort mid-conversion with reset
      @(negedge clk);
      a = 32'hC0200000;
      inp_data_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      inp_data_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("abort fixed_out", fixed_out, 32'h0);
      check("abort out_ready", 32'(out_ready), 32'h0);
      check("abort overflow", 32'(overflow), 32'h0);
      check("abort invalid", 32'(invalid), 32'h0);
      @(negedge clk);
      skip_rise = 1'b1;
      rst = 1'b0;
      @(posedge clk);
      #1 check("ready after abort", 32'(out_ready), 32'h1);

      convert(32'h3F800000, 32'h00000100, 0, 0, 6, "after reset");
      repeat (8) @(negedge clk);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
      $finish;
   end

endmodule
